// File: rtl/mul_err_sweep_if.sv
// Bundle between the sweep engine and the multiplier under test: operands out,
// product back, plus the start/status handshake and accumulated error results.
interface mul_err_sweep_if #(
  parameter int ERR_SUM_W = 32
);
  logic                 start;
  logic [7:0]           a;
  logic [7:0]           b;
  logic [15:0]          prod_in;
  logic                 busy;
  logic                 done;
  logic [16:0]          err_count;
  logic [ERR_SUM_W-1:0] err_sum;
  logic signed [32:0]   err_bias;
  logic [15:0]          max_err;

  modport master (
    output start, prod_in,
    input  a, b, busy, done, err_count, err_sum, err_bias, max_err
  );

  modport slave (
    input  start, prod_in,
    output a, b, busy, done, err_count, err_sum, err_bias, max_err
  );
endinterface

// File: rtl/mul_err_sweep.sv
// Exhaustive 8x8 multiplier checker: walks all 65536 operand pairs, compares the
// returned product with the exact one and accumulates count/sum/bias/max of the error.
module mul_err_sweep #(
  parameter int ERR_SUM_W = 32
) (
  input  logic          clk,
  input  logic          rst,
  mul_err_sweep_if.slave bus
);
  localparam logic [1:0] IDLE  = 2'd0;
  localparam logic [1:0] SWEEP = 2'd1;
  localparam logic [1:0] DRAIN = 2'd2;
  localparam logic [1:0] DONE  = 2'd3;

  logic [1:0]           state_reg;
  logic [15:0]          ab_reg;
  logic                 v1_reg;
  logic signed [16:0]   d1_reg;
  logic [15:0]          mag1_reg;
  logic [16:0]          count_reg;
  logic [ERR_SUM_W-1:0] sum_reg;
  logic signed [32:0]   bias_reg;
  logic [15:0]          max_reg;

  logic [15:0]          exact;
  logic [16:0]          diff;
  logic [16:0]          neg_diff;
  logic [15:0]          mag;

  // Difference is formed in 17 bits so the sign survives the full 0..65535 range.
  always_comb begin
    exact    = 16'(ab_reg[15:8]) * 16'(ab_reg[7:0]);
    diff     = {1'b0, bus.prod_in} - {1'b0, exact};
    neg_diff = 17'd0 - diff;
    mag      = diff[16] ? neg_diff[15:0] : diff[15:0];
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_reg <= IDLE;
      ab_reg    <= 16'h0000;
      v1_reg    <= 1'b0;
      d1_reg    <= '0;
      mag1_reg  <= '0;
      count_reg <= '0;
      sum_reg   <= '0;
      bias_reg  <= '0;
      max_reg   <= '0;
    end else begin
      if (v1_reg) begin
        if (d1_reg != 17'sd0)
          count_reg <= count_reg + 17'd1;
        sum_reg  <= sum_reg + ERR_SUM_W'(mag1_reg);
        bias_reg <= bias_reg + {{16{d1_reg[16]}}, d1_reg};
        if (mag1_reg > max_reg)
          max_reg <= mag1_reg;
      end
      v1_reg <= 1'b0;

      case (state_reg)
        IDLE, DONE: begin
          if (bus.start) begin
            state_reg <= SWEEP;
            ab_reg    <= 16'h0000;
            count_reg <= '0;
            sum_reg   <= '0;
            bias_reg  <= '0;
            max_reg   <= '0;
          end
        end
        SWEEP: begin
          d1_reg   <= $signed(diff);
          mag1_reg <= mag;
          v1_reg   <= 1'b1;
          // Natural wrap of the pair counter leaves a=b=0 for DRAIN/DONE.
          ab_reg   <= ab_reg + 16'd1;
          if (ab_reg == 16'hFFFF)
            state_reg <= DRAIN;
        end
        default: begin
          state_reg <= DONE;
        end
      endcase
    end
  end

  assign bus.a         = ab_reg[15:8];
  assign bus.b         = ab_reg[7:0];
  assign bus.busy      = (state_reg == SWEEP) || (state_reg == DRAIN);
  assign bus.done      = (state_reg == DONE);
  assign bus.err_count = count_reg;
  assign bus.err_sum   = sum_reg;
  assign bus.err_bias  = bias_reg;
  assign bus.max_err   = max_reg;
endmodule

// File: tb/tb_mul_err_sweep.sv
// Drives a randomized faulty-multiplier table into mul_err_sweep and checks every
// cycle against prefix error statistics computed directly from that table.
module tb_mul_err_sweep;
  localparam int ERR_SUM_W = 32;
  localparam int NPAIRS    = 65536;
  localparam int DONE_POS  = 65537;

  logic clk;
  logic rst;

  mul_err_sweep_if #(.ERR_SUM_W(ERR_SUM_W)) bus ();

  mul_err_sweep #(.ERR_SUM_W(ERR_SUM_W)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  logic [15:0] prod_tab [0:NPAIRS-1];
  longint cum_cnt  [0:NPAIRS];
  longint cum_sum  [0:NPAIRS];
  longint cum_bias [0:NPAIRS];
  longint cum_max  [0:NPAIRS];

  assign bus.prod_in = prod_tab[{bus.a, bus.b}];

  int vectors    = 0;
  int miscompares = 0;
  bit check_en   = 1'b0;
  int pos        = -1;

  task automatic chk(input string name, input longint act, input longint exp);
    vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("FAIL %s: got %0d expected %0d (t=%0t)", name, act, exp, $time);
    end
  endtask

  // Error statistics over the whole operand space for a simple multiplier model.
  // mode 0: exact, 1: constant zero, 2: exact plus one.
  task automatic model_totals(input int mode, output longint cnt, output longint sum,
                              output longint bias, output longint mx);
    cnt = 0; sum = 0; bias = 0; mx = 0;
    for (int i = 0; i < NPAIRS; i++) begin
      longint ex, pr, d;
      ex = longint'(i / 256) * longint'(i % 256);
      pr = (mode == 0) ? ex : (mode == 1) ? 0 : ex + 1;
      d  = pr - ex;
      if (d != 0) cnt++;
      sum  += (d < 0) ? -d : d;
      bias += d;
      if (((d < 0) ? -d : d) > mx) mx = (d < 0) ? -d : d;
    end
  endtask

  // Position within a run: -1 idle, 0..65536 sweeping (value = edges since start), 65537 done.
  always @(posedge clk) begin
    if (rst)
      pos <= -1;
    else if ((pos == -1 || pos == DONE_POS) && bus.start)
      pos <= 0;
    else if (pos >= 0 && pos < DONE_POS)
      pos <= pos + 1;
  end

  always @(negedge clk) begin
    if (check_en) begin
      int n;
      int exp_ab;
      if (pos == -1) begin
        chk("idle_busy", bus.busy, 0);
        chk("idle_done", bus.done, 0);
        chk("idle_ab", {bus.a, bus.b}, 0);
        n = 0;
      end else begin
        exp_ab = (pos <= NPAIRS) ? (pos % NPAIRS) : 0;
        chk("busy", bus.busy, (pos < DONE_POS) ? 1 : 0);
        chk("done", bus.done, (pos == DONE_POS) ? 1 : 0);
        chk("ab_seq", {bus.a, bus.b}, exp_ab);
        // Stage-1 holds the newest pair, so results lag the pair counter by one.
        n = (pos < 2) ? 0 : pos - 1;
      end
      chk("err_count", bus.err_count, cum_cnt[n]);
      chk("err_sum", bus.err_sum, cum_sum[n]);
      chk("err_bias", longint'($signed(bus.err_bias)), cum_bias[n]);
      chk("max_err", bus.max_err, cum_max[n]);
    end
  end

  initial begin
    longint c, s, bi, m;
    int lat;

    for (int i = 0; i < NPAIRS; i++) begin
      logic [15:0] ex;
      int r;
      ex = 16'((i / 256) * (i % 256));
      r  = $urandom_range(0, 3);
      case (r)
        1:       prod_tab[i] = ex + 16'($urandom_range(0, 6)) - 16'd3;
        2:       prod_tab[i] = 16'($urandom);
        default: prod_tab[i] = ex;
      endcase
    end
    prod_tab[0] = 16'hFFFF;

    cum_cnt[0] = 0; cum_sum[0] = 0; cum_bias[0] = 0; cum_max[0] = 0;
    for (int i = 0; i < NPAIRS; i++) begin
      longint d, ad;
      d  = longint'(prod_tab[i]) - longint'(i / 256) * longint'(i % 256);
      ad = (d < 0) ? -d : d;
      cum_cnt[i+1]  = cum_cnt[i] + ((d != 0) ? 1 : 0);
      cum_sum[i+1]  = cum_sum[i] + ad;
      cum_bias[i+1] = cum_bias[i] + d;
      cum_max[i+1]  = (ad > cum_max[i]) ? ad : cum_max[i];
    end

    // Hand-derived totals pin the reference arithmetic.
    model_totals(0, c, s, bi, m);
    chk("pin_exact_cnt", c, 0);
    chk("pin_exact_sum", s, 0);
    model_totals(1, c, s, bi, m);
    chk("pin_zero_cnt", c, 65025);
    chk("pin_zero_sum", s, 1065369600);
    chk("pin_zero_bias", bi, -1065369600);
    chk("pin_zero_max", m, 65025);
    model_totals(2, c, s, bi, m);
    chk("pin_plus1_cnt", c, 65536);
    chk("pin_plus1_sum", s, 65536);
    chk("pin_plus1_bias", bi, 65536);
    chk("pin_plus1_max", m, 1);
    chk("pin_first_pair_max", cum_max[1], 65535);
    chk("pin_first_pair_cnt", cum_cnt[1], 1);

    rst = 1'b1;
    bus.start = 1'b1;
    repeat (3) @(negedge clk);
    check_en = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    bus.start = 1'b0;
    repeat (2) @(negedge clk);

    // Short run aborted by a one-cycle reset.
    bus.start = 1'b1;
    @(negedge clk);
    bus.start = 1'b0;
    repeat (1000) @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    repeat (5) @(negedge clk);
    chk("abort_stays_idle", bus.busy, 0);

    // Full run with start held high: no mid-run restart, restart right after done.
    bus.start = 1'b1;
    lat = 0;
    while (!bus.done && lat < 70000) begin
      @(negedge clk);
      lat++;
    end
    chk("done_seen", bus.done, 1);
    // One edge accepts start, then 65537 edges to done.
    chk("done_latency", lat, 65538);
    chk("final_count", bus.err_count, cum_cnt[NPAIRS]);
    chk("final_sum", bus.err_sum, cum_sum[NPAIRS]);
    @(negedge clk);
    chk("restart_busy", bus.busy, 1);
    chk("restart_cleared", bus.err_sum, 0);
    @(negedge clk);
    bus.start = 1'b0;
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
    check_en = 1'b0;

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end
endmodule

// File: doc/mul_err_sweep.md
MUL_ERR_SWEEP -- requirements
Module: mul_err_sweep

Interface
REQ-001 SHALL have parameter ERR_SUM_W, default 32, meaning width of the absolute-error accumulator (legal values >= 32).
REQ-002 SHALL have port clk  input  1  single clock; all state updates on its rising edge.
REQ-003 SHALL have port rst  input  1  synchronous active-high reset.
REQ-004 SHALL have port start  input  1  level sampled each edge; begins a sweep when in IDLE or DONE.
REQ-005 SHALL have port a  output  8  registered operand A driven into the 8x8 multiplier under test.
REQ-006 SHALL have port b  output  8  registered operand B driven into the 8x8 multiplier under test.
REQ-007 SHALL have port prod_in  input  16  combinational product returned by the multiplier for the current a,b.
REQ-008 SHALL have port busy  output  1  high in SWEEP and DRAIN.
REQ-009 SHALL have port done  output  1  high in DONE; results valid and stable.
REQ-010 SHALL have port err_count  output  17  number of pairs with prod_in != a*b.
REQ-011 SHALL have port err_sum  output  ERR_SUM_W  sum of |prod_in - a*b|.
REQ-012 SHALL have port err_bias  output  33  signed two's-complement sum of (prod_in - a*b).
REQ-013 SHALL have port max_err  output  16  maximum |prod_in - a*b| seen.

Function
REQ-014 SHALL implement FSM states IDLE, SWEEP, DRAIN, DONE.
REQ-015 SHALL transition IDLE->SWEEP or DONE->SWEEP on an edge with start=1, clearing err_count, err_sum, err_bias and max_err and setting {a,b}=16'h0000 on that edge.
REQ-016 SHALL ignore start while in SWEEP or DRAIN.
REQ-017 SHALL in SWEEP, on each edge, compute exact = a*b (16-bit unsigned), register d = prod_in - exact as 17-bit signed and |d| into pipeline stage 1 with valid bit v1=1, and increment {a,b} as one 16-bit counter (b least significant).
REQ-018 SHALL, on the SWEEP edge where {a,b}=16'hFFFF, wrap {a,b} to 16'h0000 and enter DRAIN; SWEEP therefore lasts exactly 65536 cycles.
REQ-019 SHALL, on every edge where v1=1 (stage 2), increment err_count if d!=0, add |d| to err_sum, add sign-extended d to err_bias, and update max_err to max(max_err,|d|).
REQ-020 SHALL in DRAIN accumulate the final stage-1 entry, clear v1, and enter DONE on the same edge.
REQ-021 SHALL clear v1 on every edge outside SWEEP so no accumulation occurs in IDLE or DONE.
REQ-022 SHALL hold all result outputs constant in DONE until the next accepted start or reset.
REQ-023 SHALL hold a,b at 8'h00 in IDLE and DONE.
REQ-024 SHALL give done exactly 65537 edges after the start-accepting edge (65536 SWEEP + 1 DRAIN).
REQ-025 SHALL never wrap err_count, err_bias or err_sum for ERR_SUM_W>=32 (max sum 65536*65535 < 2^32).

Reset
REQ-026 SHALL on an edge with rst=1 force state=IDLE, a=b=0, v1=0, busy=0, done=0, err_count=0, err_sum=0, err_bias=0, max_err=0, overriding start and any in-progress sweep.
REQ-027 SHALL, after rst deasserts mid-sweep, remain in IDLE until a new start, never resuming the aborted sweep.

Verification
REQ-028 Exact multiplier (prod_in=a*b), pulse start -> done after 65537 edges; err_count=0, err_sum=0, err_bias=0, max_err=0.
REQ-029 prod_in tied to 16'h0000 -> err_count=65025, err_sum=1065369600, err_bias=-1065369600, max_err=65025.
REQ-030 prod_in=a*b+1 -> err_count=65536, err_sum=65536, err_bias=+65536, max_err=1.
REQ-031 start held high continuously throughout -> busy stays 1 for 65537 cycles, sweep not restarted mid-run; after done, the next edge restarts (results cleared, a=b=0, busy=1).
REQ-032 rst asserted for 1 cycle at sweep cycle 1000 -> next cycle all outputs zero, state IDLE, busy=0; subsequent start yields results identical to REQ-028..REQ-030 for the same stimulus.
REQ-033 Monitor a,b during SWEEP -> sequence (0,0),(0,1)..(0,255),(1,0)..(255,255), one pair per cycle, no gaps or repeats.
